// File: rtl/cam_i2c_pkg.sv
// Shared types and constants for the camera I2C register-write master.
package cam_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_t;

  // Quarter-bit ticks in a full write: START + 4 bytes of 9 bits + STOP
  localparam int TICKS_PER_TXN = 149;

  // Slots of a collected triple, in stream order
  localparam logic [1:0] SLOT_REG = 2'd0;
  localparam logic [1:0] SLOT_MSB = 2'd1;
  localparam logic [1:0] SLOT_LSB = 2'd2;

  // Bus byte order: address byte first, data LSB last
  localparam logic [1:0] BUS_IDX_ADDR = 2'd0;
  localparam logic [1:0] BUS_IDX_LAST = 2'd3;

  // Index of the last data bit before the acknowledge bit
  localparam logic [3:0] BIT_LAST_DATA = 4'd7;

  localparam logic [6:0] CAM0_ADDR_DEF = 7'h5D;
  localparam logic [6:0] CAM1_ADDR_DEF = 7'h48;

  // First byte of a write transaction: 7-bit address with R/W = 0
  function automatic logic [7:0] write_addr_byte(input logic [6:0] addr);
    return {addr, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_quarter_tick_gen.sv
// Quarter-bit tick generator: one-cycle pulse every CLK_DIV enabled cycles.
module i2c_quarter_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic sysClk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W    = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Divider counter, parked at zero while cleared so the first tick lands CLK_DIV cycles after enable
  always_ff @(posedge sysClk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign tick = en && !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/cam_i2c_byte_master.sv
// Collects {reg, msb, lsb} byte triples and writes each to a camera sensor as one I2C transaction.
module cam_i2c_byte_master
  import cam_i2c_pkg::*;
#(
  parameter int         CLK_DIV   = 25,
  parameter logic [6:0] CAM0_ADDR = CAM0_ADDR_DEF,
  parameter logic [6:0] CAM1_ADDR = CAM1_ADDR_DEF
) (
  input  logic       sysClk,
  input  logic       rst_n,
  input  logic [7:0] cam_i2c_byte_in,
  input  logic       byte_valid,
  input  logic       cam_id,
  output logic       ready_for_next_byte,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic       busy,
  output logic       transaction_done,
  output logic       ack_error
);

  state_t     state, state_nxt;
  logic [1:0] byte_cnt, byte_cnt_nxt;
  logic [1:0] phase, phase_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [1:0] byte_idx, byte_idx_nxt;
  logic       ready_q, ready_nxt;
  logic       scl_q, scl_nxt;
  logic       sda_q, sda_nxt;
  logic       ack_err_q, ack_err_nxt;

  logic [7:0] reg_addr, reg_addr_nxt;
  logic [7:0] data_msb, data_msb_nxt;
  logic [7:0] data_lsb, data_lsb_nxt;
  logic       cam_sel, cam_sel_nxt;

  logic       tick;
  logic       tick_en;
  logic       accept;
  logic [7:0] cur_byte;
  logic       cur_bit;

  assign accept  = byte_valid && ready_q;
  assign tick_en = (state != ST_IDLE) && (state != ST_COLLECT);

  i2c_quarter_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .sysClk(sysClk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (!tick_en),
    .tick  (tick)
  );

  // Select the byte currently being shifted onto the bus
  always_comb begin
    cur_byte = write_addr_byte(cam_sel ? CAM1_ADDR : CAM0_ADDR);
    case (byte_idx)
      2'd1:    cur_byte = reg_addr;
      2'd2:    cur_byte = data_msb;
      2'd3:    cur_byte = data_lsb;
      default: ;
    endcase
  end

  assign cur_bit = cur_byte[3'd7 - bit_cnt[2:0]];

  // Control state, reset asynchronously so the bus is abandoned at once
  always_ff @(posedge sysClk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      phase     <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      ready_q   <= 1'b0;
      scl_q     <= 1'b0;
      sda_q     <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      phase     <= phase_nxt;
      bit_cnt   <= bit_cnt_nxt;
      byte_idx  <= byte_idx_nxt;
      ready_q   <= ready_nxt;
      scl_q     <= scl_nxt;
      sda_q     <= sda_nxt;
      ack_err_q <= ack_err_nxt;
    end
  end

  // Collected bytes and camera select carry no reset; each is written before it is sent
  always_ff @(posedge sysClk) begin
    reg_addr <= reg_addr_nxt;
    data_msb <= data_msb_nxt;
    data_lsb <= data_lsb_nxt;
    cam_sel  <= cam_sel_nxt;
  end

  // Next-state: triple collection, then one quarter-bit line action per tick
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    phase_nxt    = phase;
    bit_cnt_nxt  = bit_cnt;
    byte_idx_nxt = byte_idx;
    scl_nxt      = scl_q;
    sda_nxt      = sda_q;
    ack_err_nxt  = ack_err_q;
    reg_addr_nxt = reg_addr;
    data_msb_nxt = data_msb;
    data_lsb_nxt = data_lsb;
    cam_sel_nxt  = cam_sel;

    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (accept) begin
          case (byte_cnt)
            SLOT_REG: begin
              reg_addr_nxt = cam_i2c_byte_in;
              cam_sel_nxt  = cam_id;
              ack_err_nxt  = 1'b0;
            end
            SLOT_MSB: data_msb_nxt = cam_i2c_byte_in;
            default:  data_lsb_nxt = cam_i2c_byte_in;
          endcase
          if (byte_cnt == SLOT_LSB) begin
            state_nxt    = ST_START;
            byte_cnt_nxt = '0;
            phase_nxt    = '0;
          end else begin
            state_nxt    = ST_COLLECT;
            byte_cnt_nxt = byte_cnt + 2'd1;
          end
        end
      end

      ST_START: begin
        if (tick) begin
          if (phase == 2'd0) begin
            sda_nxt   = 1'b1;
            phase_nxt = 2'd1;
          end else begin
            scl_nxt      = 1'b1;
            state_nxt    = ST_BIT;
            phase_nxt    = '0;
            bit_cnt_nxt  = '0;
            byte_idx_nxt = BUS_IDX_ADDR;
          end
        end
      end

      ST_BIT, ST_ACK: begin
        if (tick) begin
          phase_nxt = phase + 2'd1;
          case (phase)
            2'd0: sda_nxt = (state == ST_BIT) ? !cur_bit : 1'b0;
            2'd1: scl_nxt = 1'b0;
            2'd2: ;
            default: begin
              scl_nxt = 1'b1;
              if (state == ST_BIT) begin
                bit_cnt_nxt = bit_cnt + 4'd1;
                if (bit_cnt == BIT_LAST_DATA) begin
                  state_nxt = ST_ACK;
                end
              end else if (sda_in) begin
                ack_err_nxt = 1'b1;
                state_nxt   = ST_STOP;
              end else if (byte_idx == BUS_IDX_LAST) begin
                state_nxt = ST_STOP;
              end else begin
                byte_idx_nxt = byte_idx + 2'd1;
                bit_cnt_nxt  = '0;
                state_nxt    = ST_BIT;
              end
            end
          endcase
        end
      end

      ST_STOP: begin
        if (tick) begin
          phase_nxt = phase + 2'd1;
          case (phase)
            2'd0: sda_nxt = 1'b1;
            2'd1: scl_nxt = 1'b0;
            default: begin
              sda_nxt   = 1'b0;
              state_nxt = ST_DONE;
            end
          endcase
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase

    ready_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_COLLECT);
  end

  // Outputs decoded from registered state
  always_comb begin
    ready_for_next_byte = ready_q;
    scl_oe              = scl_q;
    sda_oe              = sda_q;
    ack_error           = ack_err_q;
    busy                = (state != ST_IDLE);
    transaction_done    = (state == ST_DONE);
  end

endmodule

// File: tb/tb_cam_i2c_byte_master.sv
// Bench for cam_i2c_byte_master: random byte streams, an I2C bus monitor with ACK/NACK slave,
// and a triple-level reference model of the expected transactions.
module tb_cam_i2c_byte_master;

  localparam int         DIV = 4;
  localparam logic [6:0] A0  = 7'h5D;
  localparam logic [6:0] A1  = 7'h48;

  logic       sysClk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cam_i2c_byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       cam_id = 1'b0;
  logic       ready_for_next_byte;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;
  logic       busy;
  logic       transaction_done;
  logic       ack_error;
  logic       slave_pull = 1'b0;

  // Open-drain SDA: low if either the master or the slave pulls it
  assign sda_in = !sda_oe && !slave_pull;

  cam_i2c_byte_master #(
    .CLK_DIV  (DIV),
    .CAM0_ADDR(A0),
    .CAM1_ADDR(A1)
  ) dut (
    .sysClk             (sysClk),
    .rst_n              (rst_n),
    .cam_i2c_byte_in    (cam_i2c_byte_in),
    .byte_valid         (byte_valid),
    .cam_id             (cam_id),
    .ready_for_next_byte(ready_for_next_byte),
    .scl_oe             (scl_oe),
    .sda_oe             (sda_oe),
    .sda_in             (sda_in),
    .busy               (busy),
    .transaction_done   (transaction_done),
    .ack_error          (ack_error)
  );

  initial forever #5 sysClk = ~sysClk;

  int cyc = 0;
  always @(posedge sysClk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference model: one entry per completed triple
  typedef struct {
    logic [3:0][7:0] bytes;
    int              nbytes;
    int              nack_idx;
    int              acc_edge;
  } exp_t;

  exp_t       exp_q[$];
  int         acc_n = 0;
  logic [7:0] tri_b[3];
  logic       tri_id = 1'b0;
  int         nack_cfg = -1;

  function automatic void model_accept(input logic [7:0] b, input logic id, input int ae);
    exp_t e;
    if (acc_n == 0) tri_id = id;
    tri_b[acc_n] = b;
    acc_n++;
    if (acc_n == 3) begin
      e.bytes[0] = {(tri_id ? A1 : A0), 1'b0};
      e.bytes[1] = tri_b[0];
      e.bytes[2] = tri_b[1];
      e.bytes[3] = tri_b[2];
      e.nack_idx = nack_cfg;
      e.nbytes   = (nack_cfg < 0) ? 4 : nack_cfg + 1;
      e.acc_edge = ae;
      exp_q.push_back(e);
      acc_n = 0;
    end
  endfunction

  // Stimulus queues consumed by send_stim
  logic [7:0] stim_b[$];
  logic       stim_id[$];

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) begin
      stim_b.push_back(8'($urandom));
      stim_id.push_back(1'($urandom));
    end
  endtask

  task automatic send_stim(input int max_gap);
    int sent;
    int gap;
    int guard;
    sent  = 0;
    gap   = 0;
    guard = 0;
    while (sent < stim_b.size()) begin
      @(negedge sysClk);
      guard++;
      if (guard > 20000) begin
        chk("send_timeout", sent, stim_b.size());
        break;
      end
      if (gap > 0) begin
        byte_valid = 1'b0;
        gap--;
      end else begin
        byte_valid      = 1'b1;
        cam_i2c_byte_in = stim_b[sent];
        cam_id          = stim_id[sent];
        if (ready_for_next_byte) begin
          model_accept(stim_b[sent], stim_id[sent], cyc + 1);
          sent++;
          gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        end
      end
    end
    @(negedge sysClk);
    byte_valid = 1'b0;
    stim_b.delete();
    stim_id.delete();
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 5000) begin
      @(negedge sysClk);
      guard++;
    end
    chk("idle_timeout", (exp_q.size() != 0 || busy) ? 1 : 0, 0);
  endtask

  // Bus monitor and slave
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       in_frame = 1'b0;
  logic       stop_seen = 1'b0;
  int         bitn = 0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] obs_q[$];
  int         start_cyc = 0;
  int         bus_edges = 0;
  int         done_cnt = 0;
  int         viol = 0;

  always @(negedge sysClk) begin
    logic scl;
    logic sda;
    exp_t e;
    scl = !scl_oe;
    sda = sda_in;
    if (!rst_n) begin
      in_frame   = 1'b0;
      stop_seen  = 1'b0;
      bitn       = 0;
      slave_pull = 1'b0;
      obs_q.delete();
    end else begin
      if (scl != prev_scl || sda != prev_sda) bus_edges++;
      if (prev_scl && scl && prev_sda && !sda) begin
        in_frame  = 1'b1;
        bitn      = 0;
        start_cyc = cyc;
        obs_q.delete();
      end else if (prev_scl && scl && !prev_sda && sda) begin
        if (in_frame) stop_seen = 1'b1;
        in_frame = 1'b0;
      end else if (in_frame && !prev_scl && scl) begin
        bitn++;
        if (bitn <= 8) shreg = {shreg[6:0], sda};
        if (bitn == 8) obs_q.push_back(shreg);
      end else if (in_frame && prev_scl && !scl) begin
        if (bitn == 8) begin
          slave_pull = !(exp_q.size() > 0 && exp_q[0].nack_idx == obs_q.size() - 1);
        end else if (bitn == 9) begin
          slave_pull = 1'b0;
          bitn       = 0;
        end
      end

      if (exp_q.size() > 0 && cyc >= exp_q[0].acc_edge && (ready_for_next_byte || !busy)) viol++;

      if (transaction_done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_latency", cyc + 1 - e.acc_edge, (5 + 36 * e.nbytes) * DIV + 1);
          chk("start_delay", start_cyc - e.acc_edge, DIV);
          chk("nbytes", obs_q.size(), e.nbytes);
          for (int i = 0; i < 4; i++) begin
            if (i < e.nbytes && i < obs_q.size()) chk($sformatf("byte%0d", i), obs_q[i], e.bytes[i]);
          end
          chk("ack_error_done", ack_error, (e.nack_idx >= 0) ? 1 : 0);
          chk("stop_seen", stop_seen, 1);
          stop_seen = 1'b0;
          done_cnt++;
        end
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    int r;
    int guard;

    repeat (3) @(negedge sysClk);
    chk("rst_ready", ready_for_next_byte, 0);
    chk("rst_scl", scl_oe, 0);
    chk("rst_sda", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", transaction_done, 0);
    chk("rst_ackerr", ack_error, 0);
    rst_n = 1'b1;
    @(negedge sysClk);
    chk("ready_after_rst", ready_for_next_byte, 1);
    chk("busy_after_rst", busy, 0);

    // Fixed triple to camera 0, then camera 1
    stim_b  = '{8'h08, 8'h00, 8'h05};
    stim_id = '{1'b0, 1'b0, 1'b0};
    send_stim(0);
    wait_idle();
    chk("ackerr_cam0", ack_error, 0);
    stim_b  = '{8'h08, 8'h00, 8'h05};
    stim_id = '{1'b1, 1'b0, 1'b1};
    send_stim(0);
    wait_idle();

    // NACK on the register-address byte, then clear on next slot-0 accept
    nack_cfg = 1;
    add_random(3);
    send_stim(0);
    wait_idle();
    chk("ackerr_nack", ack_error, 1);
    nack_cfg = -1;
    add_random(1);
    send_stim(0);
    chk("ackerr_clear", ack_error, 0);
    add_random(2);
    send_stim(0);
    wait_idle();

    // Continuous valid over 21 bytes
    d0 = done_cnt;
    add_random(21);
    send_stim(0);
    wait_idle();
    chk("stream_txns", done_cnt - d0, 7);

    // Random gaps and random NACK positions
    repeat (6) begin
      r        = $urandom_range(0, 5);
      nack_cfg = (r > 3) ? -1 : r;
      add_random(3);
      send_stim(3);
      wait_idle();
    end
    nack_cfg = -1;

    // Partial triple waits with no bus activity
    add_random(2);
    send_stim(2);
    e0 = bus_edges;
    repeat (1000) @(negedge sysClk);
    chk("partial_bus_edges", bus_edges - e0, 0);
    chk("partial_busy", busy, 1);
    chk("partial_ready", ready_for_next_byte, 1);
    chk("partial_scl", scl_oe, 0);
    add_random(1);
    send_stim(0);
    wait_idle();

    // Asynchronous reset in the middle of the second bus byte
    add_random(3);
    send_stim(0);
    guard = 0;
    while (obs_q.size() < 1 && guard < 2000) begin
      @(negedge sysClk);
      guard++;
    end
    chk("reset_reach_byte2", (obs_q.size() >= 1) ? 1 : 0, 1);
    repeat (20) @(negedge sysClk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_scl", scl_oe, 0);
    chk("async_rst_sda", sda_oe, 0);
    chk("async_rst_ready", ready_for_next_byte, 0);
    chk("async_rst_busy", busy, 0);
    exp_q.delete();
    acc_n = 0;
    repeat (3) @(negedge sysClk);
    rst_n = 1'b1;
    @(negedge sysClk);
    chk("ready_after_rst2", ready_for_next_byte, 1);
    chk("busy_after_rst2", busy, 0);
    add_random(3);
    send_stim(1);
    wait_idle();

    chk("ready_busy_viol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cam_i2c_byte_master.md
Name: cam_i2c_byte_master

Overview:
- Consumes the camera register-write byte stream: repeating triples of {register address, data MSB, data LSB}, byte-valid, cam_id.
- Serialises each triple into one I2C write transaction on the image-sensor bus.
- Supplies the ready_for_next_byte handshake back to the command producer.
- Sits between the camera register-write table and the open-drain SCL/SDA pads of the two image sensors.

Parameters:
- CLK_DIV, 25: sysClk cycles per I2C quarter-bit tick (10 MHz sysClk gives 100 kHz SCL); legal range 2..1023.
- CAM0_ADDR, 7'h5D: 7-bit slave address used when cam_id=0.
- CAM1_ADDR, 7'h48: 7-bit slave address used when cam_id=1.

Ports:
- sysClk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cam_i2c_byte_in  in  8  next stream byte.
- byte_valid  in  1  cam_i2c_byte_in is valid this cycle.
- cam_id  in  1  target camera; sampled with the first byte of a triple.
- ready_for_next_byte  out  1  byte accepted on the cycle where byte_valid and ready_for_next_byte are both 1.
- scl_oe  out  1  1 = drive SCL low, 0 = release.
- sda_oe  out  1  1 = drive SDA low, 0 = release.
- sda_in  in  1  SDA pad level (already synchronised externally).
- busy  out  1  a triple is partially collected or a transaction is in flight.
- transaction_done  out  1  one-cycle pulse at end of STOP.
- ack_error  out  1  NACK seen in the last transaction.

Behaviour:
- Reset values (while rst_n=0, asynchronous):
  - ready_for_next_byte=0, scl_oe=0, sda_oe=0, busy=0, transaction_done=0, ack_error=0.
  - FSM in IDLE; byte count 0; tick counter 0.
- After rst_n deasserts, ready_for_next_byte rises on the first sysClk edge.
- Reset mid-transaction abandons the bus immediately (both lines released, no STOP). No partial triple survives reset.
- Collection:
  - ready_for_next_byte=1 whenever the FSM is in IDLE/COLLECT and fewer than 3 bytes are held.
  - Each accepted byte fills slot 0, 1, 2 in order.
  - Slot 0 also latches cam_id and clears ack_error.
  - busy=1 from the first accept until transaction_done.
  - The third accept drops ready the next cycle and starts the transaction.
  - ready stays 0 until the cycle after transaction_done; byte_valid is ignored while ready=0.
  - A partial triple waits indefinitely; there is no timeout.
- Tick generator:
  - Counter runs only outside IDLE/COLLECT.
  - One tick every CLK_DIV cycles.
  - The first tick occurs CLK_DIV cycles after the third accept.
- Transaction states and per-tick line actions:
  - START (2 ticks): SDA low with SCL released; then SCL low.
  - BYTE (9 bits x 4 ticks per byte): per bit, drive SDA (MSB first), release SCL, hold, pull SCL low.
  - ACK: 9th bit. SDA is released; sda_in is sampled on the tick ending the second high quarter.
  - Byte order: {slave_addr, 1'b0}, slot 0, slot 1, slot 2.
  - STOP (3 ticks): SDA low; release SCL; release SDA.
  - DONE: transaction_done pulses for one cycle, then the FSM returns to IDLE.
- Length: 2 + 4x36 + 3 = 149 ticks. transaction_done is asserted exactly 149*CLK_DIV+1 cycles after the third accept.
- NACK handling:
  - sda_in=1 at any ACK sample sets ack_error=1.
  - Remaining bytes are skipped; the FSM goes straight to STOP.
  - transaction_done still pulses. ack_error holds until the next slot-0 accept.
- Clock stretching and arbitration are not supported; SCL is never sampled.
- Bit counter is 4 bits (0..8), byte index is 2 bits (0..3); no wrap beyond 3.

Decomposition:
- Shared package (cam_i2c_pkg):
  - FSM state enum (IDLE, COLLECT, START, BIT, ACK, STOP, DONE).
  - TICKS_PER_TXN = 149.
  - Byte-slot index constants.
  - Default CAM0/CAM1 addresses.
- One sub-module is natural: i2c_quarter_tick_gen (CLK_DIV counter with enable and synchronous clear, one-cycle tick out).

Test Plan:
- Triple 08,00,05 with cam_id=0, CLK_DIV=4, slave always ACKs -> SDA bits BA,08,00,05 decoded from SCL rising edges; transaction_done at cycle 597 after the third accept; ack_error=0.
- Same triple with cam_id=1 -> first byte 0x90; rest identical.
- Slave NACKs reg-address byte -> STOP follows that ACK bit; only 2 bytes on the bus; transaction_done pulses; ack_error=1. Next slot-0 accept clears it.
- byte_valid held high continuously over 21 bytes -> exactly 7 transactions; ready low during each; no byte dropped or duplicated; byte order preserved.
- rst_n pulled low mid-byte-2 -> within the same cycle scl_oe=0, sda_oe=0, ready=0. After release: ready=1, busy=0, next triple transmitted correctly.
- Two bytes sent, then byte_valid idle for 1000 cycles -> no bus activity, busy=1, ready=1. Third byte starts START after CLK_DIV cycles.
